// File: rtl/fpga_fabric.sv
// Feed-forward mini-FPGA: 9 five-input LUT cells in three layers joined by 13 switch boxes.
// Optional FABRIC_CFG_CHAIN_EN adds a 505-bit serial configuration chain (cfg_en/cfg_din/cfg_dout).

module fpga_lut5 (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_en,
    input  logic       cfg_din,
    output logic       cfg_dout,
    input  logic [4:0] idx,
    output logic       y
);
    logic [32:0] mem;
    logic [31:0] lut_bits;
    logic        f;
    logic        q;

    assign lut_bits = mem[31:0];
    assign f        = lut_bits[idx];
    assign y        = mem[32] ? q : f;
    assign cfg_dout = mem[32];

    // Configuration only moves while shifting; otherwise it keeps whatever was loaded.
    always_ff @(posedge clock) begin
        if (cfg_en) begin
            mem <= {mem[31:0], cfg_din};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 1'b0;
        end else if (!cfg_en) begin
            q <= f;
        end
    end
endmodule

module fpga_sbox (
    input  logic       clock,
    input  logic       cfg_en,
    input  logic       cfg_din,
    output logic       cfg_dout,
    input  logic [7:0] s,
    output logic [3:0] o
);
    logic [15:0] configure;

    assign cfg_dout = configure[15];

    always_ff @(posedge clock) begin
        if (cfg_en) begin
            configure <= {configure[14:0], cfg_din};
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_field
        logic [3:0] field;
        assign field = configure[4*gi +: 4];
        assign o[gi] = field[3] ? 1'b0 : s[field[2:0]];
    end
endmodule

module fpga_fabric (
    input  logic clock,
    input  logic reset,
`ifdef FABRIC_CFG_CHAIN_EN
    input  logic cfg_en,
    input  logic cfg_din,
    output logic cfg_dout,
`endif
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic in8,
    input  logic in9,
    input  logic in10,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4
);
    logic        shift_en;
    logic [22:0] chain;
    logic [8:0]  lut;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    logic [15:0] bus_c;
    logic [3:0]  bus_o;
    logic [7:0]  sin_a;
    logic [7:0]  sin_b;
    logic [7:0]  sin_c;
    logic [7:0]  sin_o;
    logic        unused_bits;

`ifdef FABRIC_CFG_CHAIN_EN
    assign shift_en = cfg_en;
    assign chain[0] = cfg_din;
    assign cfg_dout = chain[22];
`else
    assign shift_en = 1'b0;
    assign chain[0] = 1'b0;
`endif

    assign unused_bits = ^{bus_a[15], bus_b[15], bus_c[15], chain[22]};

    assign sin_a = {in7, in6, in5, in4, in3, in2, in1, in0};
    assign sin_b = {in1, in0, in10, in9, in8, lut[2], lut[1], lut[0]};
    assign sin_c = {in9, in8, lut[2], lut[1], lut[0], lut[5], lut[4], lut[3]};
    assign sin_o = {in10, lut[0], lut[5], lut[4], lut[3], lut[8], lut[7], lut[6]};

    // Chain order: lt0..lt8 then sb0..sb12, lt0.mem[0] nearest cfg_din.
    fpga_lut5 lt0 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[0]), .cfg_dout(chain[1]), .idx(bus_a[4:0]),   .y(lut[0]));
    fpga_lut5 lt1 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[1]), .cfg_dout(chain[2]), .idx(bus_a[9:5]),   .y(lut[1]));
    fpga_lut5 lt2 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[2]), .cfg_dout(chain[3]), .idx(bus_a[14:10]), .y(lut[2]));
    fpga_lut5 lt3 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[3]), .cfg_dout(chain[4]), .idx(bus_b[4:0]),   .y(lut[3]));
    fpga_lut5 lt4 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[4]), .cfg_dout(chain[5]), .idx(bus_b[9:5]),   .y(lut[4]));
    fpga_lut5 lt5 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[5]), .cfg_dout(chain[6]), .idx(bus_b[14:10]), .y(lut[5]));
    fpga_lut5 lt6 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[6]), .cfg_dout(chain[7]), .idx(bus_c[4:0]),   .y(lut[6]));
    fpga_lut5 lt7 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[7]), .cfg_dout(chain[8]), .idx(bus_c[9:5]),   .y(lut[7]));
    fpga_lut5 lt8 (.clock(clock), .reset(reset), .cfg_en(shift_en), .cfg_din(chain[8]), .cfg_dout(chain[9]), .idx(bus_c[14:10]), .y(lut[8]));

    fpga_sbox sb0  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[9]),  .cfg_dout(chain[10]), .s(sin_a), .o(bus_a[3:0]));
    fpga_sbox sb1  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[10]), .cfg_dout(chain[11]), .s(sin_a), .o(bus_a[7:4]));
    fpga_sbox sb2  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[11]), .cfg_dout(chain[12]), .s(sin_a), .o(bus_a[11:8]));
    fpga_sbox sb3  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[12]), .cfg_dout(chain[13]), .s(sin_a), .o(bus_a[15:12]));
    fpga_sbox sb4  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[13]), .cfg_dout(chain[14]), .s(sin_b), .o(bus_b[3:0]));
    fpga_sbox sb5  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[14]), .cfg_dout(chain[15]), .s(sin_b), .o(bus_b[7:4]));
    fpga_sbox sb6  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[15]), .cfg_dout(chain[16]), .s(sin_b), .o(bus_b[11:8]));
    fpga_sbox sb7  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[16]), .cfg_dout(chain[17]), .s(sin_b), .o(bus_b[15:12]));
    fpga_sbox sb8  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[17]), .cfg_dout(chain[18]), .s(sin_c), .o(bus_c[3:0]));
    fpga_sbox sb9  (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[18]), .cfg_dout(chain[19]), .s(sin_c), .o(bus_c[7:4]));
    fpga_sbox sb10 (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[19]), .cfg_dout(chain[20]), .s(sin_c), .o(bus_c[11:8]));
    fpga_sbox sb11 (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[20]), .cfg_dout(chain[21]), .s(sin_c), .o(bus_c[15:12]));
    fpga_sbox sb12 (.clock(clock), .cfg_en(shift_en), .cfg_din(chain[21]), .cfg_dout(chain[22]), .s(sin_o), .o(bus_o));

    assign out0 = bus_o[0];
    assign out1 = bus_o[1];
    assign out2 = bus_o[2];
    assign out3 = bus_o[3];
    assign out4 = lut[8];
endmodule

// File: tb/tb_fpga_fabric.sv
// Bench for fpga_fabric: directed scenarios plus random configs checked against a layer-by-layer model.
// Define FABRIC_CFG_CHAIN_EN to also exercise the serial configuration chain.

module tb_fpga_fabric;
    logic        clock;
    logic        reset;
    logic [10:0] pin;
    logic [4:0]  pout;
    logic        cfg_en;
    logic        cfg_din;
    logic        cfg_dout;

    logic [32:0] m_mem [9];
    logic [15:0] m_cfg [13];
    logic [8:0]  m_q;
    logic        pending_load;
    int          n_checks;
    int          n_fail;
    logic [4:0]  obs;

    fpga_fabric dut (
        .clock(clock), .reset(reset),
`ifdef FABRIC_CFG_CHAIN_EN
        .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
`endif
        .in0(pin[0]), .in1(pin[1]), .in2(pin[2]), .in3(pin[3]), .in4(pin[4]), .in5(pin[5]),
        .in6(pin[6]), .in7(pin[7]), .in8(pin[8]), .in9(pin[9]), .in10(pin[10]),
        .out0(pout[0]), .out1(pout[1]), .out2(pout[2]), .out3(pout[3]), .out4(pout[4])
    );

`ifndef FABRIC_CFG_CHAIN_EN
    assign cfg_dout = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Evaluate the fabric layer by layer from the configuration tables and current registered state.
    function automatic logic [4:0] model_out(input logic [10:0] p, output logic [8:0] fv);
        logic [8:0]  l;
        logic [7:0]  s;
        logic [15:0] bus;
        logic [3:0]  sel;
        logic [31:0] tbl;
        logic [4:0]  ix;
        l  = '0;
        fv = '0;
        for (int layer = 0; layer < 4; layer++) begin
            case (layer)
                0:       s = p[7:0];
                1:       s = {p[1], p[0], p[10], p[9], p[8], l[2], l[1], l[0]};
                2:       s = {p[9], p[8], l[2], l[1], l[0], l[5], l[4], l[3]};
                default: s = {p[10], l[0], l[5], l[4], l[3], l[8], l[7], l[6]};
            endcase
            bus = '0;
            for (int m = 0; m < 4; m++) begin
                if (layer < 3 || m == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        sel = m_cfg[layer*4+m][4*k +: 4];
                        bus[4*m+k] = sel[3] ? 1'b0 : s[sel[2:0]];
                    end
                end
            end
            if (layer < 3) begin
                for (int c = 0; c < 3; c++) begin
                    tbl = m_mem[3*layer+c][31:0];
                    ix  = bus[5*c +: 5];
                    fv[3*layer+c] = tbl[ix];
                    l[3*layer+c]  = m_mem[3*layer+c][32] ? m_q[3*layer+c] : fv[3*layer+c];
                end
            end
        end
        return {l[8], bus[3:0]};
    endfunction

    task automatic load_all();
        dut.lt0.mem = m_mem[0]; dut.lt1.mem = m_mem[1]; dut.lt2.mem = m_mem[2];
        dut.lt3.mem = m_mem[3]; dut.lt4.mem = m_mem[4]; dut.lt5.mem = m_mem[5];
        dut.lt6.mem = m_mem[6]; dut.lt7.mem = m_mem[7]; dut.lt8.mem = m_mem[8];
        dut.sb0.configure = m_cfg[0];  dut.sb1.configure = m_cfg[1];  dut.sb2.configure = m_cfg[2];
        dut.sb3.configure = m_cfg[3];  dut.sb4.configure = m_cfg[4];  dut.sb5.configure = m_cfg[5];
        dut.sb6.configure = m_cfg[6];  dut.sb7.configure = m_cfg[7];  dut.sb8.configure = m_cfg[8];
        dut.sb9.configure = m_cfg[9];  dut.sb10.configure = m_cfg[10]; dut.sb11.configure = m_cfg[11];
        dut.sb12.configure = m_cfg[12];
    endtask

    // One clock cycle: load pending config, drive inputs, compare outputs, advance model state at posedge.
    task automatic cycle(input logic [10:0] p, input logic rst, input string tag, output logic [4:0] o);
        logic [8:0] fv;
        logic [4:0] e;
        @(negedge clock);
        if (pending_load) begin
            load_all();
            pending_load = 1'b0;
        end
        pin   = p;
        reset = rst;
        #1;
        e = model_out(p, fv);
        o = pout;
        check(tag, pout, e);
        @(posedge clock);
        m_q = rst ? 9'b0 : fv;
    endtask

    task automatic base_cfg();
        for (int n = 0; n < 9; n++) m_mem[n] = '0;
        for (int n = 0; n < 13; n++) m_cfg[n] = 16'h8888;
        m_cfg[0] = 16'h3210; m_cfg[1] = 16'h7654; m_cfg[2] = 16'h3210; m_cfg[3] = 16'h7654;
        m_cfg[4] = 16'h0000; m_cfg[8] = 16'h0000; m_cfg[12] = 16'h8880;
        m_mem[3] = 33'h0_AAAAAAAA;
        m_mem[6] = 33'h0_AAAAAAAA;
        pending_load = 1'b1;
    endtask

    task automatic rand_cfg();
        for (int n = 0; n < 9; n++) m_mem[n] = {1'($urandom_range(0, 1)), 32'($urandom())};
        for (int n = 0; n < 13; n++) m_cfg[n] = 16'($urandom());
        pending_load = 1'b1;
    endtask

    initial begin
        logic [10:0] p;
        n_checks = 0;
        n_fail   = 0;
        m_q      = '0;
        pin      = '0;
        reset    = 1'b1;
        cfg_en   = 1'b0;
        cfg_din  = 1'b0;
        for (int n = 0; n < 9; n++) m_mem[n] = '0;
        for (int n = 0; n < 13; n++) m_cfg[n] = 16'h8888;
        pending_load = 1'b1;

        cycle(11'h000, 1'b1, "reset_a", obs);
        cycle(11'h7ff, 1'b1, "reset_b", obs);
        check("reset_outputs_zero", obs, 5'b0);

        // Five-input AND routed through two buffer LUTs, all combinational.
        base_cfg();
        m_mem[0] = 33'h0_80000000;
        cycle(11'h01f, 1'b0, "and_ones", obs);
        check("and_ones_direct", obs[0], 1'b1);
        for (int b = 0; b < 5; b++) begin
            p = 11'h01f & ~(11'h001 << b);
            cycle(p, 1'b0, "and_one_zero", obs);
            check("and_one_zero_direct", obs[0], 1'b0);
        end
        for (int t = 0; t < 12; t++) begin
            p = 11'($urandom());
            if (t % 3 == 0) p[4:0] = 5'h1f;
            cycle(p, 1'b0, "and_random", obs);
            check("and_random_direct", obs[0], &p[4:0]);
        end

        // Registered AND: output follows one posedge after the input change.
        m_mem[0][32] = 1'b1;
        pending_load = 1'b1;
        cycle(11'h000, 1'b0, "reg_prime", obs);
        cycle(11'h01f, 1'b0, "reg_same_cycle", obs);
        check("reg_same_cycle_direct", obs[0], 1'b0);
        cycle(11'h01f, 1'b0, "reg_next_cycle", obs);
        check("reg_next_cycle_direct", obs[0], 1'b1);

        // Reset clears the registered output but not the LUT contents.
        cycle(11'h01f, 1'b1, "reset_pulse", obs);
        check("reset_pulse_still_one", obs[0], 1'b1);
        cycle(11'h01f, 1'b0, "after_reset", obs);
        check("after_reset_zero", obs[0], 1'b0);
        check("mem_kept", dut.lt0.mem, 33'h1_80000000);
        cycle(11'h01f, 1'b0, "reset_release", obs);
        check("reset_release_one", obs[0], 1'b1);

        // Output switch box fully disabled on a random fabric.
        rand_cfg();
        m_cfg[12] = 16'h8888;
        for (int t = 0; t < 16; t++) begin
            cycle(11'($urandom()), 1'b0, "sb12_off", obs);
            check("sb12_off_zero", obs[3:0], 4'h0);
        end

        // Fully random fabrics, with occasional reset.
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            for (int t = 0; t < 20; t++) begin
                cycle(11'($urandom()), 1'($urandom_range(0, 15) == 0), "random_fabric", obs);
            end
        end

        // Five-input parity sweep.
        base_cfg();
        m_mem[0] = 33'h0_96696996;
        for (int v = 0; v < 32; v++) begin
            p = 11'($urandom()) & 11'h7e0;
            p[4:0] = 5'(v);
            cycle(p, 1'b0, "parity", obs);
            check("parity_direct", obs[0], ^p[4:0]);
        end

`ifdef FABRIC_CFG_CHAIN_EN
        begin
            logic [504:0] img;
            int pos;
            for (int n = 0; n < 9; n++) m_mem[n] = {1'($urandom_range(0, 1)), 32'($urandom())};
            for (int n = 0; n < 13; n++) m_cfg[n] = 16'($urandom());
            pos = 0;
            for (int n = 0; n < 9; n++) begin img[pos +: 33] = m_mem[n]; pos += 33; end
            for (int n = 0; n < 13; n++) begin img[pos +: 16] = m_cfg[n]; pos += 16; end
            for (int b = 504; b >= 0; b--) begin
                @(negedge clock);
                cfg_en  = 1'b1;
                cfg_din = img[b];
            end
            @(posedge clock);
            #1;
            cfg_en = 1'b0;
            check("chain_lt0", dut.lt0.mem, m_mem[0]);
            check("chain_lt8", dut.lt8.mem, m_mem[8]);
            check("chain_sb0", dut.sb0.configure, m_cfg[0]);
            check("chain_sb12", dut.sb12.configure, m_cfg[12]);
            check("chain_dout", cfg_dout, m_cfg[12][15]);
            for (int t = 0; t < 24; t++) begin
                cycle(11'($urandom()), 1'b0, "chain_fabric", obs);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
